attract_keycode_player: RTL and testbench
=========================================

Name: attract_keycode_player

Overview:
- Scripted keycode source driving the player movement controller's `keycode` input. It is the transmitter side of the per-frame keycode interface.
- In IDLE it forwards the live USB keycode. When started, it replays a stored script of (keycode, duration-in-frames) entries to run the attract/demo mode.
- It sits between the USB keycode register and the player block, and is clocked by frame_clk.

Parameters:
- DEPTH, 16, number of script entries.
- AW, 4, script index width; DEPTH <= 2**AW.
- DUR_W, 8, width of an entry's duration field, in frames.
- ABORT_ON_LIVE, 1, when 1 any nonzero live_keycode aborts playback.

Ports:
- frame_clk  in  1  frame clock (one edge per video frame)
- Reset  in  1  asynchronous, active-high reset
- start  in  1  request playback; sampled on the frame_clk edge
- abort  in  1  force return to IDLE
- live_keycode  in  8  keycode from the USB host
- keycode  out  8  registered keycode to the player block
- busy  out  1  high in LOAD, CHECK and PLAY
- done  out  1  one-frame pulse when the script completes
- step_idx  out  AW  current script index

Behaviour:
- Reset is asynchronous, active-high; the clock is frame_clk.
- Reset values: state IDLE, keycode 8'h00, busy 0, done 0, step_idx 0, duration counter 0. Reset asserted mid-playback returns to IDLE immediately with these values.
- All outputs are registered; keycode has 1-frame latency.
- States: IDLE, LOAD, CHECK, PLAY, DONE.
- IDLE:
  - keycode <= live_keycode.
  - If start=1 and live_keycode==0: idx<=0, go to LOAD.
  - If start=1 and live_keycode!=0: start is ignored.
- LOAD:
  - keycode <= 0.
  - Present idx to the synchronous ROM (1-cycle read). Go to CHECK.
- CHECK (ROM data valid):
  - If dur==0 (end marker): go to DONE.
  - Otherwise: keycode <= key, cnt <= dur-1, go to PLAY.
- PLAY:
  - If cnt!=0: cnt--, keycode held.
  - If cnt==0: keycode <= 0, then:
    - idx==DEPTH-1: go to DONE;
    - otherwise idx <= idx+1, go to LOAD.
  - Net effect: each entry's key is visible for exactly dur frames, and entries are separated by exactly 2 frames of 8'h00. This release gap lets the player block see distinct presses.
- DONE: keycode <= 0, done=1 for exactly one frame, then go to IDLE. done is 0 in every other state.
- Abort (priority over every transition except Reset):
  - Trigger: abort=1, or ABORT_ON_LIVE=1 and live_keycode!=0, in LOAD, CHECK or PLAY.
  - Response: go to IDLE on that edge with keycode <= live_keycode and done=0; idx is kept for debug.
- Simultaneous start and abort in IDLE: abort wins, stay in IDLE.
- start is level-sampled only in IDLE and ignored elsewhere.
- Counter width is DUR_W. dur is unsigned; dur=1 gives a single-frame press.
- step_idx = idx. The index never wraps silently: reaching DEPTH-1 ends or loops the script explicitly.

Optional Feature:
- Macro: ATTRACT_LOOP_EN.
- When defined: an end marker in CHECK, or release of entry DEPTH-1, sets idx<=0 and goes to LOAD instead of DONE. Playback repeats until abort or Reset; done never asserts.
- When undefined: the script runs once and ends via DONE as above.

Decomposition:
- Package attract_pkg holds:
  - keycode constants: KEY_W=8'h1A, KEY_S=8'h16, KEY_A=8'h04, KEY_D=8'h07, KEY_UP=8'h52, KEY_DN=8'h51, KEY_LT=8'h50, KEY_RT=8'h4F;
  - the state_t enum;
  - the script_entry_t struct {key[7:0], dur[DUR_W-1:0]};
  - the default script localparam array.
- Sub-module attract_script_rom: synchronous-read ROM indexed by AW bits, initialised from the package array.
- Default script: {KEY_D,60}, {KEY_W,1}, {KEY_A,3}, {8'h00,0}, with the remaining entries as end markers.

Test Plan:
- Reset pulse mid-run -> keycode 00, busy 0, done 0, step_idx 0 immediately, independent of frame_clk.
- IDLE with live_keycode=8'h07 -> keycode=07 one frame later; live=00 -> 00 one frame later.
- start=1 with live=00 -> required frame sequence:
  - 00 for 2 frames, then 07 for 60 frames;
  - 00 for 2 frames, then 1A for 1 frame;
  - 00 for 2 frames, then 04 for 3 frames;
  - 00 for 2 frames (end marker fetched);
  - DONE frame with done=1 and keycode 00, then IDLE with busy=0.
- Playback, 10th frame of entry 0, live=8'h50 -> next frame keycode=50, busy=0, done never asserts. Repeat with abort=1 and live=00 -> keycode=00, IDLE.
- start=1 while live=8'h16 -> stays IDLE, keycode=16, busy=0.
- With ATTRACT_LOOP_EN defined: after the third entry's release and the end marker fetch -> step_idx=0, keycode=07 again 2 frames after the marker fetch, done stays 0 for 3 full loops.

Source files
------------

// File: rtl/attract_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attract_pkg
// Description : Shared types and constants for the attract-mode keycode
//               player: USB HID keycodes, FSM state encoding, script entry
//               layout and the default demo script.
// Revision    : 1.0 - initial release
// ============================================================================
package attract_pkg;

    // USB HID usage IDs used by the demo script
    localparam logic [7:0] KEY_W  = 8'h1A;
    localparam logic [7:0] KEY_S  = 8'h16;
    localparam logic [7:0] KEY_A  = 8'h04;
    localparam logic [7:0] KEY_D  = 8'h07;
    localparam logic [7:0] KEY_UP = 8'h52;
    localparam logic [7:0] KEY_DN = 8'h51;
    localparam logic [7:0] KEY_LT = 8'h50;
    localparam logic [7:0] KEY_RT = 8'h4F;

    // Width of the duration field as stored in the script table
    localparam int SCRIPT_DUR_W = 8;
    // Number of entries held in the default script table
    localparam int SCRIPT_LEN   = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0]              key;
        logic [SCRIPT_DUR_W-1:0] dur;
    } script_entry_t;

    // A zero duration marks the end of the script
    localparam script_entry_t DEFAULT_SCRIPT [SCRIPT_LEN] = '{
        '{KEY_D, 8'd60}, '{KEY_W, 8'd1}, '{KEY_A, 8'd3}, '{8'h00, 8'd0},
        '{8'h00, 8'd0},  '{8'h00, 8'd0}, '{8'h00, 8'd0}, '{8'h00, 8'd0},
        '{8'h00, 8'd0},  '{8'h00, 8'd0}, '{8'h00, 8'd0}, '{8'h00, 8'd0},
        '{8'h00, 8'd0},  '{8'h00, 8'd0}, '{8'h00, 8'd0}, '{8'h00, 8'd0}
    };

endpackage : attract_pkg
`default_nettype wire

// File: rtl/attract_script_rom.sv
`default_nettype none
// ============================================================================
// Module      : attract_script_rom
// Description : Synchronous-read script ROM (one cycle read latency),
//               contents taken from attract_pkg::DEFAULT_SCRIPT. Entries
//               beyond the package table read as end markers.
// Revision    : 1.0 - initial release
// ============================================================================
module attract_script_rom
    import attract_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DUR_W = 8
) (
    input  logic             frame_clk,
    input  logic [AW-1:0]    addr,
    output logic [7:0]       key,
    output logic [DUR_W-1:0] dur
);

    logic [7:0]       rom_key [DEPTH];
    logic [DUR_W-1:0] rom_dur [DEPTH];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_rom
            if (i < SCRIPT_LEN) begin : g_init
                assign rom_key[i] = DEFAULT_SCRIPT[i].key;
                assign rom_dur[i] = DUR_W'(DEFAULT_SCRIPT[i].dur);
            end else begin : g_end_marker
                assign rom_key[i] = 8'h00;
                assign rom_dur[i] = '0;
            end
        end
    endgenerate

    // Registered read; out-of-range addresses return an end marker
    always_ff @(posedge frame_clk) begin
        if (int'(addr) < DEPTH) begin
            key <= rom_key[addr];
            dur <= rom_dur[addr];
        end else begin
            key <= 8'h00;
            dur <= '0;
        end
    end

endmodule : attract_script_rom
`default_nettype wire

// File: rtl/attract_keycode_player.sv
`default_nettype none
// ============================================================================
// Module      : attract_keycode_player
// Description : Keycode source for the player controller. Forwards the live
//               USB keycode when idle; on start replays the stored script of
//               (keycode, frames) entries with a two-frame release gap
//               between presses. Define ATTRACT_LOOP_EN to repeat the script
//               forever instead of finishing with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module attract_keycode_player
    import attract_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int DUR_W         = 8,
    parameter int ABORT_ON_LIVE = 1
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    live_keycode,
    output logic [7:0]    keycode,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           state_q,   state_d;
    logic [7:0]       keycode_q, keycode_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [AW-1:0]    idx_q,     idx_d;
    logic [DUR_W-1:0] cnt_q,     cnt_d;

    logic [7:0]       rom_key;
    logic [DUR_W-1:0] rom_dur;
    logic             live_nz;
    logic             abort_req;
    logic             active;

    attract_script_rom #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DUR_W (DUR_W)
    ) u_rom (
        .frame_clk (frame_clk),
        .addr      (idx_q),
        .key       (rom_key),
        .dur       (rom_dur)
    );

    assign live_nz   = |live_keycode;
    assign abort_req = abort | ((ABORT_ON_LIVE != 0) & live_nz);
    assign active    = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_PLAY);

    // Next-state and next-output logic for the playback sequencer
    always_comb begin
        state_d   = state_q;
        keycode_d = keycode_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                keycode_d = live_keycode;
                // A held live key blocks start so a user press is never masked
                if (start && !abort && !live_nz) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                keycode_d = 8'h00;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (rom_dur == '0) begin
                    keycode_d = 8'h00;
`ifdef ATTRACT_LOOP_EN
                    idx_d     = '0;
                    state_d   = S_LOAD;
`else
                    done_d    = 1'b1;
                    state_d   = S_DONE;
`endif
                end else begin
                    keycode_d = rom_key;
                    cnt_d     = rom_dur - DUR_W'(1);
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DUR_W'(1);
                end else begin
                    keycode_d = 8'h00;
                    if (idx_q == LAST_IDX) begin
`ifdef ATTRACT_LOOP_EN
                        idx_d   = '0;
                        state_d = S_LOAD;
`else
                        done_d  = 1'b1;
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                keycode_d = 8'h00;
                state_d   = S_IDLE;
            end
            default: begin
                keycode_d = 8'h00;
                state_d   = S_IDLE;
            end
        endcase

        // Abort overrides any playback transition; idx is kept for debug
        if (active && abort_req) begin
            state_d   = S_IDLE;
            keycode_d = live_keycode;
            done_d    = 1'b0;
            idx_d     = idx_q;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_CHECK) || (state_d == S_PLAY);
    end

    // State and registered outputs, asynchronously cleared by Reset
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            keycode_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            keycode_q <= keycode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign keycode  = keycode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;

endmodule : attract_keycode_player
`default_nettype wire

// File: tb/tb_attract_keycode_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_attract_keycode_player
// Description : Directed self-checking bench for attract_keycode_player.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attract_keycode_player;

    logic       frame_clk;
    logic       Reset;
    logic       start;
    logic       abort;
    logic [7:0] live_keycode;
    logic [7:0] keycode;
    logic       busy;
    logic       done;
    logic [3:0] step_idx;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_key [$];
    logic [3:0] exp_idx [$];

    attract_keycode_player #(
        .DEPTH         (16),
        .AW            (4),
        .DUR_W         (8),
        .ABORT_ON_LIVE (1)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .start        (start),
        .abort        (abort),
        .live_keycode (live_keycode),
        .keycode      (keycode),
        .busy         (busy),
        .done         (done),
        .step_idx     (step_idx)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame: crosses exactly one rising edge, returns on the falling edge
    task automatic step();
        @(negedge frame_clk);
    endtask

    task automatic steps(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    // Expected busy frames after the start edge, up to the end-marker fetch
    task automatic build_script();
        logic [7:0] keys [3];
        int         durs [3];
        keys[0] = 8'h07; durs[0] = 60;
        keys[1] = 8'h1A; durs[1] = 1;
        keys[2] = 8'h04; durs[2] = 3;
        for (int e = 0; e < 3; e++) begin
            repeat (2) begin exp_key.push_back(8'h00); exp_idx.push_back(4'(e)); end
            for (int d = 0; d < durs[e]; d++) begin
                exp_key.push_back(keys[e]);
                exp_idx.push_back(4'(e));
            end
        end
        repeat (2) begin exp_key.push_back(8'h00); exp_idx.push_back(4'd3); end
    endtask

    // Issue start from IDLE; returns on the first frame after the start edge
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int loops;
        build_script();
        Reset = 1'b1; start = 1'b0; abort = 1'b0; live_keycode = 8'h00;
        steps(3);
        check("reset_key",  32'(keycode),  32'h00);
        check("reset_busy", 32'(busy),     32'h0);
        check("reset_done", 32'(done),     32'h0);
        check("reset_idx",  32'(step_idx), 32'h0);
        Reset = 1'b0;
        step();

        // Live forwarding in IDLE, one frame latency
        live_keycode = 8'h07; step();
        check("idle_fwd_07", 32'(keycode), 32'h07);
        live_keycode = 8'h00; step();
        check("idle_fwd_00", 32'(keycode), 32'h00);

        // Full script playback
        do_start();
`ifdef ATTRACT_LOOP_EN
        loops = 3;
`else
        loops = 1;
`endif
        for (int l = 0; l < loops; l++) begin
            for (int f = 0; f < exp_key.size(); f++) begin
                if (l != 0 || f != 0) step();
                check($sformatf("play_key l%0d f%0d", l, f), 32'(keycode), 32'(exp_key[f]));
                check($sformatf("play_idx l%0d f%0d", l, f), 32'(step_idx), 32'(exp_idx[f]));
                check($sformatf("play_busy l%0d f%0d", l, f), 32'(busy), 32'h1);
                check($sformatf("play_done l%0d f%0d", l, f), 32'(done), 32'h0);
            end
        end
`ifdef ATTRACT_LOOP_EN
        // Restarts at entry 0 after the marker fetch
        step();
        check("loop_idx0", 32'(step_idx), 32'h0);
        check("loop_key0", 32'(keycode),  32'h00);
        abort = 1'b1; step(); abort = 1'b0;
        check("loop_abort_busy", 32'(busy), 32'h0);
        check("loop_abort_done", 32'(done), 32'h0);
`else
        step();
        check("done_pulse", 32'(done),     32'h1);
        check("done_key",   32'(keycode),  32'h00);
        check("done_busy",  32'(busy),     32'h0);
        check("done_idx",   32'(step_idx), 32'h3);
        step();
        check("post_done",  32'(done),     32'h0);
        check("post_busy",  32'(busy),     32'h0);
`endif
        step();

        // Live key aborts on the 10th frame of entry 0 (frame index 11)
        do_start();
        steps(11);
        check("pre_abort_key", 32'(keycode), 32'h07);
        live_keycode = 8'h50; step();
        check("live_abort_key",  32'(keycode), 32'h50);
        check("live_abort_busy", 32'(busy),    32'h0);
        check("live_abort_done", 32'(done),    32'h0);
        check("live_abort_idx",  32'(step_idx), 32'h0);
        live_keycode = 8'h00; step();
        check("live_abort_done2", 32'(done),   32'h0);
        check("live_abort_key2",  32'(keycode), 32'h00);

        // Explicit abort with no live key
        do_start();
        steps(11);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_key",  32'(keycode), 32'h00);
        check("abort_busy", 32'(busy),    32'h0);
        step();
        check("abort_idle_busy", 32'(busy), 32'h0);
        check("abort_idle_done", 32'(done), 32'h0);

        // Start ignored while a live key is held
        live_keycode = 8'h16; start = 1'b1; step();
        check("blocked_key",  32'(keycode), 32'h16);
        check("blocked_busy", 32'(busy),    32'h0);
        step();
        check("blocked_busy2", 32'(busy),   32'h0);
        start = 1'b0; live_keycode = 8'h00; step();

        // Start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'h0);
        step();
        check("start_abort_busy2", 32'(busy), 32'h0);

        // Asynchronous reset mid-run, during entry 2 (idx 2)
        do_start();
        steps(68);
        check("pre_reset_idx", 32'(step_idx), 32'h2);
        check("pre_reset_key", 32'(keycode),  32'h04);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_key",  32'(keycode),  32'h00);
        check("async_reset_busy", 32'(busy),     32'h0);
        check("async_reset_done", 32'(done),     32'h0);
        check("async_reset_idx",  32'(step_idx), 32'h0);
        step();
        Reset = 1'b0;
        step();
        check("after_reset_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_attract_keycode_player
`default_nettype wire
